spi_vec_bank: RTL

//  Parametrised SPI-loaded, double-buffered register bank; generalises the single POV vector loader to NUM_SLOTS addressable slots.
//  SPI mode 0 slave (sample on SCLK rise, MSB first) receives {mode, addr, data} frames.

---
 rtl/spi_vec_bank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_vec_bank.sv
// SPI mode-0 loaded, double-buffered register bank of NUM_SLOTS vectors.
// Frames {mode, addr, data} either write live slots or stage them for load_if_ready.
module spi_vec_bank #(
  parameter int DATA_BITS   = 74,
  parameter int NUM_SLOTS   = 4,
  parameter int ADDR_BITS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_SLOTS*DATA_BITS-1:0] INIT = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_sclk,
  input  logic                           i_ss_n,
  input  logic                           i_mosi,
  input  logic                           load_if_ready,
  input  logic                           i_hold,
  input  logic                           i_cancel,
  output logic [NUM_SLOTS*DATA_BITS-1:0] o_data,
  output logic [NUM_SLOTS-1:0]           o_pending,
  output logic [NUM_SLOTS-1:0]           o_update,
  output logic                           o_frame_err,
  output logic [7:0]                     o_err_count
);

  localparam int FB = 1 + ADDR_BITS + DATA_BITS;
  localparam int CW = $clog2(FB + 1);
  localparam int LW = NUM_SLOTS * DATA_BITS;

  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], i_sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], i_ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
    end
  end

  logic sclk_rise;
  logic ss_act;
  logic mosi_s;

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign ss_act    = ~ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FB-1:0] sh_q, sh_d;
  logic          done_q, done_d;
  logic          abort;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    abort  = 1'b0;
    if (!ss_act) begin
      cnt_d = '0;
      abort = (cnt_q != '0);
    end else if (sclk_rise) begin
      sh_d = {sh_q[FB-2:0], mosi_s};
      if (cnt_q == CW'(FB - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  logic                 f_mode;
  logic [ADDR_BITS-1:0] f_addr;
  logic [DATA_BITS-1:0] f_data;
  logic                 addr_ok;

  assign f_mode  = sh_q[FB-1];
  assign f_addr  = sh_q[DATA_BITS +: ADDR_BITS];
  assign f_data  = sh_q[DATA_BITS-1:0];
  assign addr_ok = ({1'b0, f_addr} < (ADDR_BITS + 1)'(NUM_SLOTS));

  logic [LW-1:0]        live_q, live_d;
  logic [LW-1:0]        stg_q, stg_d;
  logic [NUM_SLOTS-1:0] pend_q, pend_d;
  logic [NUM_SLOTS-1:0] upd_q, upd_d;
  logic                 err_q, err_d;
  logic [7:0]           ecnt_q, ecnt_d;
  logic                 do_load;

  assign do_load = load_if_ready & ~i_hold & ~i_cancel;

  // Load reads old staging first so a same-cycle deferred commit lands after it
  always_comb begin
    live_d = live_q;
    stg_d  = stg_q;
    pend_d = pend_q;
    upd_d  = '0;
    err_d  = abort;
    ecnt_d = ecnt_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (do_load && pend_q[k]) begin
        live_d[k*DATA_BITS +: DATA_BITS] = stg_q[k*DATA_BITS +: DATA_BITS];
        upd_d[k]  = 1'b1;
        pend_d[k] = 1'b0;
      end
    end
    if (done_q) begin
      if (!addr_ok) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (f_addr == ADDR_BITS'(k)) begin
            if (f_mode) begin
              live_d[k*DATA_BITS +: DATA_BITS] = f_data;
              upd_d[k]  = 1'b1;
              pend_d[k] = 1'b0;
            end else begin
              stg_d[k*DATA_BITS +: DATA_BITS] = f_data;
              pend_d[k] = 1'b1;
            end
          end
        end
      end
    end
    if (i_cancel) begin
      pend_d = '0;
    end
    if (err_d && ecnt_q != 8'hFF) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
      live_q <= INIT;
      stg_q  <= '0;
      pend_q <= '0;
      upd_q  <= '0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      done_q <= done_d;
      live_q <= live_d;
      stg_q  <= stg_d;
      pend_q <= pend_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign o_data      = live_q;
  assign o_pending   = pend_q;
  assign o_update    = upd_q;
  assign o_frame_err = err_q;
  assign o_err_count = ecnt_q;

endmodule
